// File: rtl/timer_bank.sv
// timer_bank: three independent prescaled interval timers.
// Each channel runs while its start level is high, pulses its
// interrupt once at the programmed period, then parks until
// start is released.
// Ports:
//   clock_in, reset_in            clock, sync active-high reset
//   t0/t1/t2_start_in             per-channel run levels
//   period_wr_in, period_sel_in,
//   period_data_in                runtime period write port
//   t0/t1/t2_int_out              one-cycle expiry pulses
//   busy_out[2:0]                 channel n in RUN
module timer_bank #(
   parameter int CNT_W     = 16,
   parameter int DIV       = 1000,
   parameter int T0_PERIOD = 500,
   parameter int T1_PERIOD = 500,
   parameter int T2_PERIOD = 2000
) (
   input  logic             clock_in,
   input  logic             reset_in,
   input  logic             t0_start_in,
   input  logic             t1_start_in,
   input  logic             t2_start_in,
   input  logic             period_wr_in,
   input  logic [1:0]       period_sel_in,
   input  logic [CNT_W-1:0] period_data_in,
   output logic             t0_int_out,
   output logic             t1_int_out,
   output logic             t2_int_out,
   output logic [2:0]       busy_out
);

   localparam int DIV_E = (DIV < 1) ? 1 : DIV;
   localparam int PRE_W = (DIV_E > 1) ? $clog2(DIV_E) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV_E - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   logic [2:0] w_start;
   logic [2:0] w_int;
   logic [2:0] w_busy;

   assign w_start = {t2_start_in, t1_start_in, t0_start_in};

   for (genvar g = 0; g < 3; g++) begin : g_ch
      localparam logic [CNT_W-1:0] P_RST =
         CNT_W'((g == 0) ? T0_PERIOD :
                (g == 1) ? T1_PERIOD : T2_PERIOD);

      state_t           r_state;
      state_t           w_state_nx;
      logic [PRE_W-1:0] r_pre;
      logic [PRE_W-1:0] w_pre_nx;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nx;
      logic [CNT_W-1:0] r_ap;
      logic [CNT_W-1:0] w_ap_nx;
      logic [CNT_W-1:0] r_period;
      logic             r_int;
      logic             w_int_nx;
      logic             w_wr;
      logic             w_tick;
      logic             w_last;
      logic [CNT_W-1:0] w_ap_cur;

      assign w_wr = period_wr_in &&
                    (period_sel_in == 2'(g));

      // The entry edge already counts as the first prescaler
      // step, so it uses the period register value directly;
      // a zero period runs as one tick.
      assign w_ap_cur =
         (r_state != IDLE) ? r_ap :
         (r_period == '0)  ? CNT_W'(1) : r_period;

      assign w_tick = (r_pre == PRE_MAX);
      assign w_last = w_tick &&
                      (r_cnt == w_ap_cur - 1'b1);

      always_comb begin
         w_state_nx = r_state;
         w_pre_nx   = r_pre;
         w_cnt_nx   = r_cnt;
         w_ap_nx    = r_ap;
         w_int_nx   = 1'b0;
         unique case (r_state)
            IDLE, RUN: begin
               if (!w_start[g]) begin
                  w_state_nx = IDLE;
                  w_pre_nx   = '0;
                  w_cnt_nx   = '0;
               end else begin
                  w_ap_nx = w_ap_cur;
                  if (w_last) begin
                     w_state_nx = DONE;
                     w_int_nx   = 1'b1;
                     w_pre_nx   = '0;
                     w_cnt_nx   = '0;
                  end else if (w_tick) begin
                     w_state_nx = RUN;
                     w_pre_nx   = '0;
                     w_cnt_nx   = r_cnt + 1'b1;
                  end else begin
                     w_state_nx = RUN;
                     w_pre_nx   = r_pre + 1'b1;
                  end
               end
            end
            DONE: begin
               if (!w_start[g]) begin
                  w_state_nx = IDLE;
               end
            end
            default: begin
               w_state_nx = IDLE;
            end
         endcase
      end

      always_ff @(posedge clock_in) begin
         if (reset_in) begin
            r_state  <= IDLE;
            r_pre    <= '0;
            r_cnt    <= '0;
            r_ap     <= '0;
            r_int    <= 1'b0;
            r_period <= P_RST;
         end else begin
            r_state <= w_state_nx;
            r_pre   <= w_pre_nx;
            r_cnt   <= w_cnt_nx;
            r_ap    <= w_ap_nx;
            r_int   <= w_int_nx;
            if (w_wr) begin
               r_period <= period_data_in;
            end
         end
      end

      assign w_int[g]  = r_int;
      assign w_busy[g] = (r_state == RUN);
   end

   assign t0_int_out = w_int[0];
   assign t1_int_out = w_int[1];
   assign t2_int_out = w_int[2];
   assign busy_out   = w_busy;

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed scoreboard bench for timer_bank.
// DUT a uses DIV=4, DUT b uses DIV=1.
module tb_timer_bank;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  a_s = '0;
   logic        a_wr = 1'b0;
   logic [1:0]  a_sel = '0;
   logic [15:0] a_data = '0;
   logic [2:0]  b_s = '0;
   logic        b_wr = 1'b0;
   logic [1:0]  b_sel = '0;
   logic [15:0] b_data = '0;

   logic [2:0]  a_int;
   logic [2:0]  a_busy;
   logic [2:0]  b_int;
   logic [2:0]  b_busy;
   logic [11:0] obs;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      string       tag;
      logic [11:0] v;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   timer_bank #(
      .CNT_W(16), .DIV(4),
      .T0_PERIOD(2), .T1_PERIOD(3), .T2_PERIOD(5)
   ) u_a (
      .clock_in      (clk),
      .reset_in      (rst),
      .t0_start_in   (a_s[0]),
      .t1_start_in   (a_s[1]),
      .t2_start_in   (a_s[2]),
      .period_wr_in  (a_wr),
      .period_sel_in (a_sel),
      .period_data_in(a_data),
      .t0_int_out    (a_int[0]),
      .t1_int_out    (a_int[1]),
      .t2_int_out    (a_int[2]),
      .busy_out      (a_busy)
   );

   timer_bank #(
      .CNT_W(16), .DIV(1),
      .T0_PERIOD(2), .T1_PERIOD(3), .T2_PERIOD(4)
   ) u_b (
      .clock_in      (clk),
      .reset_in      (rst),
      .t0_start_in   (b_s[0]),
      .t1_start_in   (b_s[1]),
      .t2_start_in   (b_s[2]),
      .period_wr_in  (b_wr),
      .period_sel_in (b_sel),
      .period_data_in(b_data),
      .t0_int_out    (b_int[0]),
      .t1_int_out    (b_int[1]),
      .t2_int_out    (b_int[2]),
      .busy_out      (b_busy)
   );

   assign obs = {a_int, a_busy, b_int, b_busy};

   function automatic logic [11:0] mk(
      input int d, input logic [2:0] i, input logic [2:0] b);
      return (d == 0) ? {i, b, 6'b0} : {6'b0, i, b};
   endfunction

   task automatic tick(input string tag, input logic [11:0] e);
      exp_t x;
      exp_q.push_back('{tag, e});
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      n_assert++;
      assert (obs === x.v) else begin
         n_fail++;
         $error("FAIL %s obs=%h exp=%h", x.tag, obs, x.v);
      end
   endtask

   task automatic idle(input string tag, input int n);
      for (int k = 0; k < n; k++) tick(tag, 12'h000);
   endtask

   task automatic busy(input string tag, input int d,
                       input int ch, input int n);
      logic [2:0] oh;
      oh = 3'(1 << ch);
      for (int k = 0; k < n; k++) tick(tag, mk(d, 3'b000, oh));
   endtask

   // start must already be high; expiry on edge number 'edges'
   task automatic run_ch(input string tag, input int d,
                         input int ch, input int edges);
      logic [2:0] oh;
      oh = 3'(1 << ch);
      busy(tag, d, ch, edges - 1);
      tick(tag, mk(d, oh, 3'b000));
   endtask

   initial begin
      idle("reset", 2);
      rst = 1'b0;
      idle("post_reset", 1);

      a_s[1] = 1'b1;
      run_ch("a_full", 0, 1, 12);
      idle("a_no_refire", 6);
      a_s[1] = 1'b0;
      idle("a_release", 1);

      a_s[1] = 1'b1;
      busy("a_pre_abort", 0, 1, 8);
      a_s[1] = 1'b0;
      idle("a_abort", 1);
      a_s[1] = 1'b1;
      run_ch("a_rerun", 0, 1, 12);
      a_s[1] = 1'b0;
      idle("a_release2", 1);

      a_s[1] = 1'b1;
      busy("a_pre_drop", 0, 1, 11);
      a_s[1] = 1'b0;
      idle("a_drop_on_exp", 2);

      a_s[1] = 1'b1;
      run_ch("a_run3", 0, 1, 12);
      a_s[1] = 1'b0;
      idle("a_release3", 1);
      a_s[1] = 1'b1;
      run_ch("a_rerise", 0, 1, 12);
      a_s[1] = 1'b0;
      idle("a_release4", 1);

      b_s[0] = 1'b1;
      busy("b_p2_e1", 1, 0, 1);
      b_wr = 1'b1;
      b_sel = 2'd0;
      b_data = 16'd5;
      tick("b_p2_exp", mk(1, 3'b001, 3'b000));
      b_wr = 1'b0;
      idle("b_done", 1);
      b_s[0] = 1'b0;
      idle("b_release", 1);
      b_s[0] = 1'b1;
      run_ch("b_p5", 1, 0, 5);
      b_s[0] = 1'b0;
      idle("b_release", 1);

      b_wr = 1'b1;
      b_sel = 2'd3;
      b_data = 16'd7;
      idle("b_sel3", 1);
      b_wr = 1'b0;
      b_s[1] = 1'b1;
      run_ch("b_sel3_ch1", 1, 1, 3);
      b_s[1] = 1'b0;
      idle("b_release", 1);
      b_s[2] = 1'b1;
      run_ch("b_sel3_ch2", 1, 2, 4);
      b_s[2] = 1'b0;
      idle("b_release", 1);
      b_s[0] = 1'b1;
      run_ch("b_sel3_ch0", 1, 0, 5);
      b_s[0] = 1'b0;
      idle("b_release", 1);

      b_s[1] = 1'b1;
      b_wr = 1'b1;
      b_sel = 2'd1;
      b_data = 16'd1;
      busy("b_wr_entry", 1, 1, 1);
      b_wr = 1'b0;
      run_ch("b_wr_entry", 1, 1, 2);
      b_s[1] = 1'b0;
      idle("b_release", 1);
      b_s[1] = 1'b1;
      run_ch("b_p1_ch1", 1, 1, 1);
      b_s[1] = 1'b0;
      idle("b_release", 1);

      b_wr = 1'b1;
      b_sel = 2'd2;
      b_data = 16'd0;
      idle("b_wr_zero", 1);
      b_wr = 1'b0;
      b_s[2] = 1'b1;
      run_ch("b_zero_ch2", 1, 2, 1);
      b_s[2] = 1'b0;
      idle("b_release", 1);

      b_wr = 1'b1;
      b_sel = 2'd0;
      b_data = 16'd1;
      idle("b_wr_ch0", 1);
      b_wr = 1'b0;
      b_s = 3'b111;
      tick("b_simul", mk(1, 3'b111, 3'b000));
      idle("b_simul_hold", 2);
      b_s = 3'b000;
      idle("b_release", 1);

      a_s[1] = 1'b1;
      busy("a_pre_rst", 0, 1, 11);
      rst = 1'b1;
      idle("a_rst_on_exp", 1);
      rst = 1'b0;
      a_s[1] = 1'b0;
      idle("a_after_rst", 2);

      b_s[0] = 1'b1;
      run_ch("b_dflt_ch0", 1, 0, 2);
      b_s[0] = 1'b0;
      idle("b_release", 1);
      b_s[1] = 1'b1;
      run_ch("b_dflt_ch1", 1, 1, 3);
      b_s[1] = 1'b0;
      idle("b_release", 1);
      b_s[2] = 1'b1;
      run_ch("b_dflt_ch2", 1, 2, 4);
      b_s[2] = 1'b0;
      idle("b_release", 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Three-channel interval timer that generates the t0/t1/t2 expiry pulses for the LED sequencing controller and consumes its level-held start signals.
- Each channel counts prescaled clock ticks while its start input is high, emits a one-cycle interrupt at the programmed period, then parks until start is released.
- Per-channel periods are preset by parameter and can be rewritten at runtime through a small write port.

Parameters:
- CNT_W, 16, width of each channel period counter.
- DIV, 1000, prescaler ratio (clocks per tick), >=1; values below 1 treated as 1.
- T0_PERIOD, 500, reset value of channel 0 period (ticks).
- T1_PERIOD, 500, reset value of channel 1 period (ticks).
- T2_PERIOD, 2000, reset value of channel 2 period (ticks).

Ports:
- clock_in  in  1  system clock, all logic on rising edge.
- reset_in  in  1  synchronous, active-high reset.
- t0_start_in  in  1  channel 0 run level (from controller t0_start_out).
- t1_start_in  in  1  channel 1 run level.
- t2_start_in  in  1  channel 2 run level.
- period_wr_in  in  1  period write strobe, one write per cycle.
- period_sel_in  in  2  channel select for write: 0/1/2; 3 ignored.
- period_data_in  in  CNT_W  new period in ticks.
- t0_int_out  out  1  channel 0 expiry pulse (to controller t0_int_in).
- t1_int_out  out  1  channel 1 expiry pulse.
- t2_int_out  out  1  channel 2 expiry pulse.
- busy_out  out  3  bit n high while channel n is in RUN.

Behaviour:
- One clock; reset is synchronous and active-high: clock port clock_in, reset port reset_in.
- Reset, sampled on a rising edge:
  - all int_out=0, busy_out=0, all channels IDLE, prescalers and counters = 0.
  - period registers reload T0/T1/T2_PERIOD.
  - reset wins over every other input in the same cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- Per-channel FSM, channels fully independent:
  - IDLE: pre=0, cnt=0. On an edge with start=1: latch active_period = period register (0 treated as 1), pre=1 (or tick on the first edge if DIV=1), go to RUN.
  - RUN:
    - Each edge with start=1: pre increments; at pre==DIV-1, pre wraps to 0 and cnt increments.
    - Expiry is on the edge where pre==DIV-1 and cnt==active_period-1: int_out<=1 for the following cycle, state -> DONE.
    - Edge with start=0: abort, go to IDLE, clear pre and cnt, no int.
  - DONE: int_out=0 after its single cycle. Stay in DONE while start=1 (no re-fire). Start=0 -> IDLE.
- Latency: with start held high from edge E1, int_out is high in the cycle after edge E(active_period*DIV). Exactly one int per start assertion.
- busy_out[n]=1 exactly while channel n is in RUN (registered).
- Period write: on an edge with period_wr_in=1 and sel<=2, the period register of the selected channel takes period_data_in.
  - A write affects only runs that enter RUN after the write edge.
  - A write on the same edge as RUN entry is not used for that run; the old value is latched.
  - A write to a running or DONE channel never alters the current run.
- Boundary cases:
  - Start falling on the expiry edge: no int, go to IDLE.
  - Start re-rising the cycle after release from DONE starts a fresh full period.
  - Counter width: active_period up to 2^CNT_W-1 ticks; no overflow possible because cnt stops at active_period-1.
  - Simultaneous expiries on several channels: each pulses independently in the same cycle.
  - Reset mid-run: no int, and any pending int is suppressed.

Test Plan:
- DIV=4, T1_PERIOD=3; reset, then t1_start_in=1 held -> t1_int_out high for exactly 1 cycle after 12th edge; busy_out[1] high edges 1-12, low after; no second pulse while start stays high.
- DIV=4, period 3; drop t1_start_in after 8 edges, re-raise -> no int at edge 12; int after 12 edges measured from re-raise.
- Write period_sel_in=0, data=5 while channel 0 running with period 2 (DIV=1) -> current run pulses after 2 edges; next run pulses after 5 edges; sel=3 write leaves all periods unchanged.
- DIV=1, all periods 1, all starts rise together -> t0/t1/t2_int_out all high in the cycle after the first edge, one cycle each.
- Assert reset_in on the edge where expiry would occur -> no int, busy_out=0, periods back to parameter defaults.
- Closed loop with the controller (DIV=1, T1=3, T0=2) -> t1_int pulse once per ON phase, t0_int pulse once per OFF phase; controller advances ON->DEC on the edge after each t1 pulse.
